fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the Controller and downstream of the InstructionCache. Holds the fetch PC, issues one word request at a time to the instruction cache, and buffers returned instructions with their PCs in a small queue presented to the decoder over a valid/ready handshake. Applies branch redirects from the PC/ALU side (branch, unconditional-branch and zero flags plus offset), flushing queued and in-flight wrong-path instructions.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetchState_t;

  typedef struct packed {
    logic [PC_W-1:0] data;
    logic [PC_W-1:0] pc;
  } fetchEntry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {instruction, pc} pairs; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [31:0]                pushData,
  input  logic [31:0]                pushPc,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       headValid,
  output logic [31:0]                headData,
  output logic [31:0]                headPc
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetchEntry_t        mem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic               doPush;
  logic               doPop;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign doPush = push && (count != CNT_W'(DEPTH));
  assign doPop  = pop && headValid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= ptrInc(wrPtr);
      if (doPop)  rdPtr <= ptrInc(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush && !flush) mem[wrPtr] <= '{data: pushData, pc: pushPc};
  end

  assign headValid = (count != '0);
  assign headData  = headValid ? mem[rdPtr].data : '0;
  assign headPc    = headValid ? mem[rdPtr].pc   : '0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding cache request FSM,
// branch redirect with wrong-path drop, and the decoder-facing queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic        branch_flag,
  input  logic        uncond_branch_flag,
  input  logic        zero_flag,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_offset
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  fetchState_t       state;
  fetchState_t       stateNext;
  logic [PC_W-1:0]   fetchPc;
  logic [PC_W-1:0]   fetchPcNext;
  logic [PC_W-1:0]   target;
  logic [CNT_W-1:0]  count;
  logic              taken;
  logic              push;
  logic              pop;

  assign taken     = redirect_valid && (uncond_branch_flag || (branch_flag && zero_flag));
  assign target    = branch_pc + (branch_offset << 2);
  assign imem_req  = (state == S_REQ) && (count < CNT_W'(QUEUE_DEPTH)) && !reset;
  assign imem_addr = fetchPc;
  assign pop       = instr_valid && instr_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_REQ;
      fetchPc <= RESET_PC;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
    end
  end

  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    push        = 1'b0;
    case (state)
      S_REQ:   if (imem_req) stateNext = S_WAIT;
      S_WAIT:  if (imem_valid) begin
                 push        = 1'b1;
                 fetchPcNext = fetchPc + PC_W'(INSTR_BYTES);
                 stateNext   = S_REQ;
               end
      S_DROP:  if (imem_valid) stateNext = S_REQ;
      default: stateNext = S_REQ;
    endcase
    // A request is still outstanding after this cycle exactly when the
    // normal next state is not S_REQ; on redirect that one becomes wrong-path.
    if (taken) begin
      push        = 1'b0;
      fetchPcNext = target;
      stateNext   = (stateNext == S_REQ) ? S_REQ : S_DROP;
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushData (imem_rdata),
    .pushPc   (fetchPc),
    .pop      (pop),
    .flush    (taken),
    .count    (count),
    .headValid(instr_valid),
    .headData (instr_data),
    .headPc   (instr_pc)
  );
endmodule
